// File: rtl/ov7670_sccb_config.sv
// ov7670_sccb_config
//   Walks an external synchronous ROM of {sub_addr, value} pairs and issues
//   one 3-phase SCCB write (DEV_ID, sub_addr, value) per entry, so the camera
//   is configured before capture is enabled. sub_addr 8'hF0 is an inline delay
//   of value*DELAY_UNIT clocks; sub_addr 8'hFF ends the table.
// Ports
//   clk_i        system clock, rising edge
//   rst_i        asynchronous active-high reset
//   start_i      1-cycle pulse, runs the table from entry 0 (ignored while busy)
//   rom_addr_o   table index; rom_data_i is valid 1 clk after it changes
//   rom_data_i   {sub_addr[15:8], value[7:0]}
//   sio_c_o      SCCB clock, push-pull
//   sio_d_out_o  SCCB data value
//   sio_d_oe_o   1 = drive sio_d_out_o, 0 = release
//   busy_o       high from accepted start until the table finishes
//   cfg_done_o   high once the table finished; cleared by the next start
//   wr_count_o   SCCB writes completed this run, saturating at 255
module ov7670_sccb_config #(
  parameter int unsigned CLK_DIV    = 250,
  parameter logic [7:0]  DEV_ID     = 8'h42,
  parameter int unsigned NUM_REGS   = 128,
  parameter int unsigned DELAY_UNIT = 25000,
  parameter int unsigned GAP_TICKS  = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  output logic [6:0]  rom_addr_o,
  input  logic [15:0] rom_data_i,
  output logic        sio_c_o,
  output logic        sio_d_out_o,
  output logic        sio_d_oe_o,
  output logic        busy_o,
  output logic        cfg_done_o,
  output logic [7:0]  wr_count_o
);
  localparam int unsigned      DIV_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [6:0]       ADDR_LAST = 7'(NUM_REGS - 1);
  localparam logic [31:0]      GAP_LAST  = 32'(GAP_TICKS - 1);
  localparam logic [7:0]       SUB_END   = 8'hFF;
  localparam logic [7:0]       SUB_DLY   = 8'hF0;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_START, S_BIT, S_STOP, S_GAP, S_DELAY, S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       qtr_q, qtr_d;      // quarter-bit phase (also step in START/STOP)
  logic [4:0]       bit_q, bit_d;      // 0..26 within the 27-bit frame
  logic [31:0]      cnt_q, cnt_d;      // FETCH clk wait / GAP ticks / DELAY countdown
  logic [26:0]      shift_q, shift_d;
  logic [6:0]       addr_q, addr_d;
  logic [7:0]       wr_q, wr_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             scl_q, scl_d;
  logic             sda_q, sda_d;
  logic             oe_q, oe_d;

  logic       tick;
  logic       adv;       // move to the next table entry (or finish)
  logic       refetch;   // FETCH re-entered from FETCH: restart its timers
  logic       ack_bit;
  logic [7:0] sub, val;

  assign tick    = (div_q == DIV_LAST);
  assign sub     = rom_data_i[15:8];
  assign val     = rom_data_i[7:0];
  // 9th bit of each byte belongs to the slave; the line is released for it
  assign ack_bit = (bit_q == 5'd8) || (bit_q == 5'd17) || (bit_q == 5'd26);

  always_comb begin
    state_d = state_q;
    div_d   = tick ? '0 : div_q + DIV_W'(1);
    qtr_d   = qtr_q;
    bit_d   = bit_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    addr_d  = addr_q;
    wr_d    = wr_q;
    busy_d  = busy_q;
    done_d  = done_q;
    scl_d   = scl_q;
    sda_d   = sda_q;
    oe_d    = oe_q;
    adv     = 1'b0;
    refetch = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          addr_d  = '0;
          wr_d    = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          cnt_d   = '0;
          state_d = S_FETCH;
        end
      end

      // rom_data_i reflects addr_q from the second clock in this state
      S_FETCH: begin
        cnt_d = cnt_q + 32'd1;
        if (cnt_q == 32'd1) begin
          if (sub == SUB_END) begin
            state_d = S_DONE;
          end else if (sub == SUB_DLY) begin
            if (val == 8'd0) begin
              adv = 1'b1;
            end else begin
              cnt_d   = 32'(val) * DELAY_UNIT - 32'd1;
              state_d = S_DELAY;
            end
          end else begin
            shift_d = {DEV_ID, 1'b0, sub, 1'b0, val, 1'b0};
            state_d = S_START;
          end
        end
      end

      // data falls while clock is still high, then clock falls
      S_START: begin
        if (tick) begin
          qtr_d = qtr_q + 2'd1;
          if (qtr_q == 2'd0) begin
            sda_d = 1'b0;
          end else begin
            scl_d   = 1'b0;
            state_d = S_BIT;
          end
        end
      end

      S_BIT: begin
        if (tick) begin
          qtr_d = qtr_q + 2'd1;
          case (qtr_q)
            2'd0: begin
              sda_d = shift_q[26];
              oe_d  = ~ack_bit;
            end
            2'd1: scl_d = 1'b1;
            2'd2: ;
            default: begin
              scl_d   = 1'b0;
              shift_d = {shift_q[25:0], 1'b0};
              if (bit_q == 5'd26) state_d = S_STOP;
              else                bit_d   = bit_q + 5'd1;
            end
          endcase
        end
      end

      // drive data low under a low clock, raise clock, then data rises
      S_STOP: begin
        if (tick) begin
          qtr_d = qtr_q + 2'd1;
          case (qtr_q)
            2'd0: begin
              oe_d  = 1'b1;
              sda_d = 1'b0;
            end
            2'd1: scl_d = 1'b1;
            default: begin
              sda_d   = 1'b1;
              if (wr_q != 8'hFF) wr_d = wr_q + 8'd1;
              cnt_d   = '0;
              state_d = S_GAP;
            end
          endcase
        end
      end

      S_GAP: begin
        if (tick) begin
          if (cnt_q == GAP_LAST) adv = 1'b1;
          else                   cnt_d = cnt_q + 32'd1;
        end
      end

      S_DELAY: begin
        if (cnt_q == 32'd0) adv = 1'b1;
        else                cnt_d = cnt_q - 32'd1;
      end

      S_DONE: begin
        scl_d   = 1'b1;
        sda_d   = 1'b1;
        oe_d    = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    // rom_addr never passes the last table slot
    if (adv) begin
      if (addr_q == ADDR_LAST) begin
        state_d = S_DONE;
      end else begin
        addr_d  = addr_q + 7'd1;
        cnt_d   = '0;
        refetch = 1'b1;
        state_d = S_FETCH;
      end
    end

    if ((state_d != state_q) || refetch) begin
      div_d = '0;
      qtr_d = '0;
      bit_d = '0;
    end

    if ((state_d == S_DONE) && (state_q != S_DONE)) begin
      busy_d = 1'b0;
      done_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      qtr_q   <= '0;
      bit_q   <= '0;
      cnt_q   <= '0;
      shift_q <= '0;
      addr_q  <= '0;
      wr_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      scl_q   <= 1'b1;
      sda_q   <= 1'b1;
      oe_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      qtr_q   <= qtr_d;
      bit_q   <= bit_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      addr_q  <= addr_d;
      wr_q    <= wr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      scl_q   <= scl_d;
      sda_q   <= sda_d;
      oe_q    <= oe_d;
    end
  end

  assign rom_addr_o  = addr_q;
  assign sio_c_o     = scl_q;
  assign sio_d_out_o = sda_q;
  assign sio_d_oe_o  = oe_q;
  assign busy_o      = busy_q;
  assign cfg_done_o  = done_q;
  assign wr_count_o  = wr_q;

endmodule

// File: tb/tb_ov7670_sccb_config.sv
// Bench for ov7670_sccb_config: a synchronous ROM model, a passive SCCB bus
// decoder with timing checks, a table-level reference model, a vector table,
// randomized tables and hand sequences for reset and start corner cases.
module tb_ov7670_sccb_config;
  localparam int CLK_DIV    = 4;
  localparam int GAP_TICKS  = 2;
  localparam int DELAY_UNIT = 10;
  localparam int NUM_REGS   = 4;
  localparam logic [7:0] DEV_ID = 8'h42;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [6:0]  rom_addr;
  logic [15:0] rom_data;
  logic        sio_c, sio_d_out, sio_d_oe, busy, cfg_done;
  logic [7:0]  wr_count;

  ov7670_sccb_config #(
    .CLK_DIV(CLK_DIV), .DEV_ID(DEV_ID), .NUM_REGS(NUM_REGS),
    .DELAY_UNIT(DELAY_UNIT), .GAP_TICKS(GAP_TICKS)
  ) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start),
    .rom_addr_o(rom_addr), .rom_data_i(rom_data),
    .sio_c_o(sio_c), .sio_d_out_o(sio_d_out), .sio_d_oe_o(sio_d_oe),
    .busy_o(busy), .cfg_done_o(cfg_done), .wr_count_o(wr_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0] rom [128];
  always @(posedge clk) rom_data <= rom[rom_addr];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  // ---------------- passive bus decoder ----------------
  logic        prev_scl = 1'b1, prev_sda = 1'b1, in_frame = 1'b0;
  int          nbits = 0;
  logic [26:0] word = '0;
  int          t_last_rise = 0, t_start_fall = 0, t_stop_rise = 0;
  int          tim_err = 0, frm_err = 0, both_err = 0, max_addr = 0;
  int          first_start = -1, last_stop = -1;
  logic [23:0] got_q[$];

  always @(negedge clk) begin
    logic scl, sda;
    scl = sio_c;
    sda = sio_d_oe ? sio_d_out : 1'b1;   // released line reads high via pull-up
    if (rst) begin
      in_frame = 1'b0;
    end else begin
      if (busy && cfg_done) both_err++;
      if (busy && int'(rom_addr) > max_addr) max_addr = int'(rom_addr);
      if (prev_scl && scl && prev_sda && !sda) begin
        if (in_frame) frm_err++;
        in_frame = 1'b1; nbits = 0; word = '0; t_start_fall = cyc;
        if (first_start < 0) first_start = cyc;
      end else if (prev_scl && scl && !prev_sda && sda) begin
        if (!in_frame || nbits != 27) frm_err++;
        else begin
          got_q.push_back({word[26:19], word[17:10], word[8:1]});
          if (cyc - t_stop_rise != CLK_DIV) tim_err++;
        end
        in_frame = 1'b0; last_stop = cyc;
      end else if (!prev_scl && scl && in_frame) begin
        if (nbits == 27) t_stop_rise = cyc;
        else begin
          if (nbits > 0 && cyc - t_last_rise != 4 * CLK_DIV) tim_err++;
          word = {word[25:0], sda}; nbits++; t_last_rise = cyc;
        end
      end else if (prev_scl && !scl && in_frame) begin
        if (nbits == 0) begin
          if (cyc - t_start_fall != CLK_DIV) tim_err++;
        end else if (cyc - t_last_rise != 2 * CLK_DIV) tim_err++;
      end
    end
    prev_scl = scl;
    prev_sda = sda;
  end

  // ---------------- reference model ----------------
  logic [15:0] tbl [NUM_REGS];
  logic [23:0] exp_q[$];

  // Expected writes, and cycles from the start request to the first START
  // data fall: 1 clk to accept, 2 clk per fetch, value*DELAY_UNIT per delay,
  // then one tick into START.
  function automatic void model(output int nwr, output int lat);
    int acc;
    logic [7:0] s, v;
    exp_q.delete(); nwr = 0; lat = -1; acc = 1;
    for (int i = 0; i < NUM_REGS; i++) begin
      s = tbl[i][15:8]; v = tbl[i][7:0];
      if (s == 8'hFF) break;
      if (s == 8'hF0) acc += 2 + int'(v) * DELAY_UNIT;
      else begin
        if (nwr == 0) lat = acc + 2 + CLK_DIV;
        exp_q.push_back({DEV_ID, s, v});
        nwr++;
      end
    end
  endfunction

  task automatic load_rom();
    for (int i = 0; i < 128; i++) rom[i] = (i < NUM_REGS) ? tbl[i] : 16'h2222;
  endtask

  task automatic clr_mon();
    got_q.delete(); tim_err = 0; frm_err = 0; both_err = 0; max_addr = 0;
    first_start = -1; last_stop = -1;
  endtask

  function automatic logic [19:0] idle_vec();
    return {sio_c, sio_d_out, sio_d_oe, busy, cfg_done, rom_addr, wr_count};
  endfunction
  localparam logic [19:0] RST_VEC = {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 7'd0, 8'd0};

  // One full table run, checked against the model
  task automatic run(input string nm, input int exp_wr, input bit use_exp,
                     input bit spam, input bit tail);
    int nwr, lat, t0;
    bit seen;
    model(nwr, lat);
    load_rom();
    clr_mon();
    @(negedge clk); start = 1'b1; t0 = cyc;
    @(negedge clk); start = 1'b0;
    chk({nm, "_busy_on"}, busy, 1);
    chk({nm, "_done_clr"}, cfg_done, 0);
    chk({nm, "_wr0"}, wr_count, 0);
    seen = 1'b0;
    for (int k = 0; k < 20000; k++) begin
      @(negedge clk);
      if (cfg_done) begin seen = 1'b1; break; end
      start = spam && (k % 97 == 50);
    end
    start = 1'b0;
    chk({nm, "_finished"}, seen, 1);
    chk({nm, "_wr_count"}, wr_count, use_exp ? exp_wr : nwr);
    chk({nm, "_busy_off"}, busy, 0);
    chk({nm, "_nwrites"}, got_q.size(), nwr);
    for (int i = 0; i < exp_q.size(); i++)
      if (i < got_q.size()) chk($sformatf("%s_write%0d", nm, i), got_q[i], exp_q[i]);
    chk({nm, "_timing"}, tim_err, 0);
    chk({nm, "_framing"}, frm_err, 0);
    chk({nm, "_busy_and_done"}, both_err, 0);
    chk({nm, "_addr_bound"}, max_addr < NUM_REGS, 1);
    if (nwr > 0) chk({nm, "_first_start"}, first_start - t0, lat);
    if (tail) chk({nm, "_done_latency"}, (cyc - last_stop) <= GAP_TICKS * CLK_DIV + 2, 1);
  endtask

  typedef struct packed {
    logic [3:0][15:0] e;
    logic [7:0]       wr;
  } vec_t;

  function automatic vec_t mk(input logic [15:0] a0, a1, a2, a3, input logic [7:0] w);
    vec_t v;
    v.e[0] = a0; v.e[1] = a1; v.e[2] = a2; v.e[3] = a3; v.wr = w;
    return v;
  endfunction

  initial begin
    vec_t vecs[6];
    bit   hit;
    vecs[0] = mk(16'h1280, 16'hFF00, 16'h0000, 16'h0000, 8'd1);
    vecs[1] = mk(16'hF003, 16'h1101, 16'hFF00, 16'h0000, 8'd1);
    vecs[2] = mk(16'h3A04, 16'h40D0, 16'h8C00, 16'h3E19, 8'd4);
    vecs[3] = mk(16'hFF00, 16'h1280, 16'h1280, 16'h1280, 8'd0);
    vecs[4] = mk(16'hF000, 16'hF002, 16'h55AA, 16'hFF00, 8'd1);
    vecs[5] = mk(16'h01FF, 16'h0200, 16'hF001, 16'h7F7E, 8'd3);

    for (int i = 0; i < 128; i++) rom[i] = 16'h2222;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_state", idle_vec(), RST_VEC);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_after_reset", idle_vec(), RST_VEC);

    // vector table; vec2 also carries start spam while busy
    for (int v = 0; v < 6; v++) begin
      for (int i = 0; i < NUM_REGS; i++) tbl[i] = vecs[v].e[i];
      run($sformatf("vec%0d", v), int'(vecs[v].wr), 1'b1, v == 2, v == 0);
    end

    // reset during bit 12 of the second write, then rerun from entry 0
    for (int i = 0; i < NUM_REGS; i++) tbl[i] = vecs[2].e[i];
    load_rom();
    clr_mon();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    hit = 1'b0;
    for (int k = 0; k < 5000; k++) begin
      @(negedge clk);
      if (got_q.size() == 1 && in_frame && nbits == 12) begin hit = 1'b1; break; end
    end
    chk("midreset_reached", hit, 1);
    rst = 1'b1;
    #1;
    chk("midreset_async", idle_vec(), RST_VEC);
    @(negedge clk);
    chk("midreset_next_clk", idle_vec(), RST_VEC);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    run("rerun", 4, 1'b1, 1'b0, 1'b0);

    // start coincident with reset: reset wins
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    repeat (5) @(negedge clk);
    chk("start_with_reset", idle_vec(), RST_VEC);

    // randomized tables with start spam while busy
    for (int r = 0; r < 12; r++) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        int kind;
        logic [7:0] s;
        kind = $urandom_range(0, 9);
        if (kind == 0) tbl[i] = {8'hFF, 8'($urandom)};
        else if (kind == 1) tbl[i] = {8'hF0, 8'($urandom_range(0, 4))};
        else begin
          s = 8'($urandom);
          if (s == 8'hFF || s == 8'hF0) s = 8'h3C;
          tbl[i] = {s, 8'($urandom)};
        end
      end
      run($sformatf("rnd%0d", r), 0, 1'b0, 1'b1, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
